divide_issue_stage: RTL and testbench
=====================================

DIVIDE_ISSUE_STAGE -- requirements
Module: divide_issue_stage

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the number of cycles the combinational divider is given to settle after its inputs change (legal range 1-15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a divide; sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  1 = SDIV, 0 = UDIV.
REQ-006 SHALL have port rn_val  input  64  dividend operand from the register file.
REQ-007 SHALL have port rm_val  input  64  divisor operand from the register file.
REQ-008 SHALL have port rd_addr  input  5  destination register index.
REQ-009 SHALL have port div_dividend  output  64  registered unsigned dividend driven to the combinational divider.
REQ-010 SHALL have port div_divisor  output  64  registered unsigned divisor driven to the combinational divider.
REQ-011 SHALL have port div_quotient  input  64  unsigned quotient returned by the combinational divider.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  single-cycle pulse; result, wb_addr and div_by_zero are valid while it is high.
REQ-014 SHALL have port result  output  64  final signed or unsigned quotient.
REQ-015 SHALL have port wb_addr  output  5  captured rd_addr.
REQ-016 SHALL have port div_by_zero  output  1  high with done when the captured divisor is 0.

Function
REQ-017 SHALL implement the states IDLE, PREP, WAIT, FIX and DONE with the following transitions:
- IDLE -> PREP on start.
- PREP -> WAIT unconditionally.
- WAIT -> FIX when the settle counter reaches 1.
- FIX -> DONE unconditionally.
- DONE -> IDLE unconditionally.
REQ-018 SHALL, in IDLE with start=1, capture rn_val, rm_val, is_signed and rd_addr into internal registers at the clock edge.
REQ-019 SHALL, in PREP, compute for signed operations:
- div_dividend = |dividend|, div_divisor = |divisor| (two's complement magnitude);
- neg_q = sign(rn) XOR sign(rm).
For unsigned operations, the raw values pass through and neg_q = 0.
REQ-020 SHALL load the settle counter with SETTLE_CYCLES on PREP -> WAIT and decrement it by 1 per WAIT cycle.
REQ-021 SHALL hold div_dividend and div_divisor constant from the PREP edge until the next capture.
REQ-022 SHALL, in FIX, register result = neg_q ? -div_quotient (mod 2^64) : div_quotient; the quotient truncates toward zero.
REQ-023 SHALL, in FIX with captured divisor = 0, register result = 0 and div_by_zero = 1, ignoring div_quotient.
REQ-024 SHALL produce result = 0x8000_0000_0000_0000 for signed 0x8000_0000_0000_0000 / -1 (wrap, no trap); the magnitude 2^63 passes through the unsigned path.
REQ-025 SHALL assert done for exactly the one cycle spent in DONE; done rises SETTLE_CYCLES+3 rising edges after the edge that sampled start.
REQ-026 SHALL hold result, wb_addr and div_by_zero stable from DONE until the next FIX.
REQ-027 SHALL ignore start while busy=1; no queueing and no operand overwrite.
REQ-028 SHALL accept a new start in the IDLE cycle immediately after DONE (back-to-back throughput of one divide per SETTLE_CYCLES+4 cycles).

Reset
REQ-029 SHALL, while reset_n=0, immediately force the state to IDLE and drive busy=0, done=0, result=0, wb_addr=0, div_by_zero=0, div_dividend=0, div_divisor=1 and settle counter=0.
REQ-030 SHALL abort an in-flight operation on reset with no done pulse; the first start after reset_n rises behaves as from power-up.

Verification
REQ-031 SHALL cover unsigned 2000/50 with SETTLE_CYCLES=2 -> done 5 edges after start, result=40, div_by_zero=0, wb_addr as driven.
REQ-032 SHALL cover signed -34/3 -> result=-11 (0xFFFF_FFFF_FFFF_FFF5); signed 19/-6 -> result=-3; signed -20/-5 -> result=4.
REQ-033 SHALL cover signed and unsigned 7/0 -> result=0, div_by_zero=1, done pulse of exactly one cycle.
REQ-034 SHALL cover signed 0x8000_0000_0000_0000 / -1 -> result=0x8000_0000_0000_0000; unsigned 0xFFFF_FFFF_FFFF_FFFF/1 -> same value.
REQ-035 SHALL cover start pulsed again in WAIT with different operands -> ignored; the first operation's result is returned, then a back-to-back start in IDLE succeeds.
REQ-036 SHALL cover reset_n low during WAIT -> busy=0 and all outputs zero without waiting for a clock edge, no done pulse; a subsequent 20/5 returns 4.

Source files
------------

// File: rtl/divide_issue_stage.sv
// divide_issue_stage
//   Issue/retire wrapper around an external single-shot combinational
//   64-bit unsigned divider. Captures an SDIV/UDIV request, presents the
//   operand magnitudes to the divider, waits SETTLE_CYCLES for it to
//   settle, then applies the quotient sign and reports the result.
//
//   Handshake: a request is accepted only when busy=0 (IDLE) and start=1
//   at a rising edge; while busy=1, start is ignored (no queueing). done
//   is a one-cycle pulse, and result/wb_addr/div_by_zero are valid while
//   it is high and remain stable until the next operation's FIX cycle.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start, is_signed      request strobe, 1 = SDIV / 0 = UDIV
//   rn_val, rm_val        dividend / divisor from the register file
//   rd_addr               destination register index
//   div_dividend/divisor  registered unsigned operands to the divider
//   div_quotient          unsigned quotient from the divider
//   busy, done            not-IDLE flag, one-cycle completion pulse
//   result, wb_addr       final quotient and its destination index
//   div_by_zero           captured divisor was zero
//   dbg_state             current FSM state, for observation only
module divide_issue_stage #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [63:0] rn_val,
  input  logic [63:0] rm_val,
  input  logic [4:0]  rd_addr,
  output logic [63:0] div_dividend,
  output logic [63:0] div_divisor,
  input  logic [63:0] div_quotient,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [4:0]  wb_addr,
  output logic        div_by_zero,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_WAIT = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t      state, state_nxt;
  logic [63:0] rn_q, rm_q;
  logic        signed_q;
  logic [4:0]  rd_q;
  logic        neg_q;
  logic [3:0]  cnt;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_PREP;
      end
      S_PREP: state_nxt = S_WAIT;
      // The divider is considered settled after the counter's last cycle.
      S_WAIT: if (cnt == 4'd1) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dbg_state = state;

  // Operand capture; start is only honoured in IDLE so operands of an
  // in-flight divide can never be overwritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rn_q     <= '0;
      rm_q     <= '0;
      signed_q <= 1'b0;
      rd_q     <= '0;
    end else if (state == S_IDLE && start) begin
      rn_q     <= rn_val;
      rm_q     <= rm_val;
      signed_q <= is_signed;
      rd_q     <= rd_addr;
    end
  end

  // Divider operands and quotient sign. Two's-complement negation of
  // 0x8000_0000_0000_0000 yields itself, which is exactly the unsigned
  // magnitude 2^63, so the most-negative dividend needs no special case.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_dividend <= '0;
      div_divisor  <= 64'd1;
      neg_q        <= 1'b0;
    end else if (state == S_PREP) begin
      div_dividend <= (signed_q && rn_q[63]) ? (64'd0 - rn_q) : rn_q;
      div_divisor  <= (signed_q && rm_q[63]) ? (64'd0 - rm_q) : rm_q;
      neg_q        <= signed_q && (rn_q[63] ^ rm_q[63]);
    end
  end

  // Settle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == S_PREP) begin
      cnt <= SETTLE_INIT;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Result registers, updated only in FIX so they hold through DONE and
  // the following idle period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result      <= '0;
      wb_addr     <= '0;
      div_by_zero <= 1'b0;
    end else if (state == S_FIX) begin
      wb_addr <= rd_q;
      if (rm_q == 64'd0) begin
        result      <= '0;
        div_by_zero <= 1'b1;
      end else begin
        result      <= neg_q ? (64'd0 - div_quotient) : div_quotient;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divide_issue_stage.sv
// tb_divide_issue_stage
//   Directed plus randomized checks of divide_issue_stage with
//   SETTLE_CYCLES=2. The external divider is modelled with a settle time:
//   its quotient is deliberately wrong until its inputs have been stable
//   for SETTLE_CYCLES cycles. Expected results come from a reference
//   model using plain signed/unsigned arithmetic, queued at issue and
//   popped when done pulses.
module tb_divide_issue_stage;

  localparam int S = 2;
  localparam int W = 70;  // {div_by_zero, wb_addr[4:0], result[63:0]}
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [63:0] rn_val, rm_val;
  logic [4:0]  rd_addr;
  logic [63:0] div_dividend, div_divisor, div_quotient;
  logic        busy, done;
  logic [63:0] result;
  logic [4:0]  wb_addr;
  logic        div_by_zero;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  divide_issue_stage #(.SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .is_signed    (is_signed),
    .rn_val       (rn_val),
    .rm_val       (rm_val),
    .rd_addr      (rd_addr),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .wb_addr      (wb_addr),
    .div_by_zero  (div_by_zero),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- divider model with settle time ----------------
  int          age = 100;
  logic [63:0] last_dd = '0, last_dv = '0;
  logic [63:0] true_q;

  always @(negedge clk) begin
    if (div_dividend !== last_dd || div_divisor !== last_dv) age <= 0;
    else if (age < 100) age <= age + 1;
    last_dd <= div_dividend;
    last_dv <= div_divisor;
  end

  assign true_q       = (div_divisor == 64'd0) ? '1 : div_dividend / div_divisor;
  assign div_quotient = (age >= S) ? true_q : ~true_q;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input bit sgn, input logic [63:0] a,
                                         input logic [63:0] b, input logic [4:0] rd);
    logic [63:0] q;
    bit dz;
    dz = (b == 64'd0);
    if (dz)                                q = '0;
    else if (sgn && a == MIN64 && b == '1) q = MIN64;
    else if (sgn)                          q = $signed(a) / $signed(b);
    else                                   q = a / b;
    return {dz, rd, q};
  endfunction

  function automatic logic [63:0] mag(input bit sgn, input logic [63:0] x);
    return (sgn && $signed(x) < 0) ? 64'd0 - x : x;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one divide, optionally pokes a second start during WAIT, then
  // waits (bounded) for done and scores the result against exp_q.
  task automatic do_div(input bit sgn, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input bit poke);
    logic [W-1:0] expv;
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1; is_signed = sgn; rn_val = a; rm_val = b; rd_addr = rd;
    exp_q.push_back(model(sgn, a, b, rd));
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs: a correct design ignores them from here on.
    is_signed = ~sgn; rn_val = rand64(); rm_val = rand64(); rd_addr = ~rd;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); n++; #1;
      if (n == 1) begin
        check("div_dividend", div_dividend, mag(sgn, a));
        check("div_divisor",  div_divisor,  mag(sgn, b));
        if (poke) begin
          start = 1'b1; rn_val = a + 64'd7; rm_val = 64'd3;
        end
      end
      if (n == 2) start = 1'b0;
      if (done) seen = 1'b1;
    end
    expv = exp_q.pop_front();
    if (!seen) begin
      check("done_timeout", 64'(dbg_state), 64'hDEAD);
    end else begin
      // Latency counted with the start-sampling edge as edge 1.
      check("done_latency", 64'(n + 1), 64'(S + 3));
      check("result",       result,          expv[63:0]);
      check("wb_addr",      64'(wb_addr),    64'(expv[68:64]));
      check("div_by_zero",  64'(div_by_zero), 64'(expv[69]));
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'd0);
      check("idle_after_done", 64'(busy), 64'd0);
      check("result_held", result, expv[63:0]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          sgn;
    int          mode;
    logic [63:0] a, b;

    reset_n = 1'b0; start = 1'b0; is_signed = 1'b0;
    rn_val = '0; rm_val = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",    64'(busy),        64'd0);
    check("rst_done",    64'(done),        64'd0);
    check("rst_result",  result,           64'd0);
    check("rst_dz",      64'(div_by_zero), 64'd0);
    check("rst_dividend", div_dividend,    64'd0);
    check("rst_divisor",  div_divisor,     64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    do_div(1'b0, 64'd2000, 64'd50, 5'd7, 1'b0);
    do_div(1'b1, 64'd0 - 64'd34, 64'd3, 5'd1, 1'b0);
    check("neg34_div3_const", result, 64'hFFFF_FFFF_FFFF_FFF5);
    do_div(1'b1, 64'd19, 64'd0 - 64'd6, 5'd2, 1'b0);
    do_div(1'b1, 64'd0 - 64'd20, 64'd0 - 64'd5, 5'd3, 1'b0);
    do_div(1'b1, 64'd7, 64'd0, 5'd4, 1'b0);
    do_div(1'b0, 64'd7, 64'd0, 5'd5, 1'b0);
    do_div(1'b1, MIN64, '1, 5'd6, 1'b0);
    do_div(1'b0, '1, 64'd1, 5'd8, 1'b0);

    // start during WAIT is ignored; then a back-to-back start from IDLE
    do_div(1'b0, 64'd90, 64'd9, 5'd9, 1'b1);
    do_div(1'b0, 64'd81, 64'd9, 5'd10, 1'b0);

    // Reset in the middle of WAIT aborts silently
    do_div(1'b0, 64'd100, 64'd3, 5'd11, 1'b0);
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; rn_val = 64'd1000; rm_val = 64'd7; rd_addr = 5'd12;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_busy",    64'(busy),        64'd0);
    check("async_done",    64'(done),        64'd0);
    check("async_result",  result,           64'd0);
    check("async_wb_addr", 64'(wb_addr),     64'd0);
    check("async_dz",      64'(div_by_zero), 64'd0);
    check("async_dividend", div_dividend,    64'd0);
    check("async_divisor",  div_divisor,     64'd1);
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_no_done", 64'(done), 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    do_div(1'b0, 64'd20, 64'd5, 5'd13, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      sgn  = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 4);
      case (mode)
        0: begin a = rand64(); b = rand64(); end
        1: begin
          a = 64'($signed($urandom_range(0, 65535) - 32768));
          b = 64'($signed($urandom_range(0, 255) - 128));
        end
        2: begin a = rand64(); b = 64'd0; end
        3: begin a = rand64(); b = ($urandom_range(0, 1) == 1) ? '1 : 64'd1; end
        default: begin a = rand64(); b = 64'($urandom_range(1, 1000)); end
      endcase
      do_div(sgn, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
